networkadapter_conf_arb: RTL and testbench



---
 rtl/networkadapter_conf_arb_pkg.sv | 17 +
 rtl/networkadapter_conf_arb_if.sv | 31 +++
 rtl/networkadapter_conf_arb_arb_rr.sv | 27 ++
 rtl/networkadapter_conf_arb.sv | 116 +++++++++++
 tb/tb_networkadapter_conf_arb.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/networkadapter_conf_arb_pkg.sv
// Shared NA configuration definitions: arbiter FSM states and the CDC config register index.
package networkadapter_conf_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Word index (addr[11:2]) of the CDC configuration register, the only writable one.
  localparam logic [9:0] REG_CDC_CONF = 10'h42;

  function automatic logic [9:0] word_idx(input logic [15:0] addr);
    return addr[11:2];
  endfunction

endpackage

// File: rtl/networkadapter_conf_arb_if.sv
// Requester bus plus configuration register port of the NA config arbiter.
interface networkadapter_conf_arb_if #(
  parameter int NREQ = 2,
  parameter int DW   = 32
);
  // Handshake: a requester holds req_valid with addr/we/din; the arbiter latches the fields at
  // grant and answers with a one-cycle req_ack (req_err alongside on rejected writes, req_dout
  // valid in the same cycle). There is no back-pressure on the ack; conf_* is a one-cycle access.
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*16-1:0] req_addr;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*DW-1:0] req_din;
  logic [NREQ-1:0]    req_ack;
  logic [NREQ-1:0]    req_err;
  logic [DW-1:0]      req_dout;
  logic [15:0]        conf_addr;
  logic [DW-1:0]      conf_din;
  logic               conf_en;
  logic               conf_we;
  logic [DW-1:0]      conf_dout;

  modport slave (
    input  req_valid, req_addr, req_we, req_din, conf_dout,
    output req_ack, req_err, req_dout, conf_addr, conf_din, conf_en, conf_we
  );

  modport master (
    output req_valid, req_addr, req_we, req_din, conf_dout,
    input  req_ack, req_err, req_dout, conf_addr, conf_din, conf_en, conf_we
  );
endinterface

// File: rtl/networkadapter_conf_arb_arb_rr.sv
// Combinational round-robin pick: first requester after the last granted one wins.
module arb_rr #(
  parameter int NREQ = 2,
  parameter int LW   = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [LW-1:0]   i_last,
  output logic [NREQ-1:0] o_grant
);

  logic w_found;
  int   w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = (int'(i_last) + k) % NREQ;
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/networkadapter_conf_arb.sv
// Arbitrates NREQ requesters onto the single NA configuration register port (IDLE/ACCESS/RESP).
module networkadapter_conf_arb
  import networkadapter_conf_arb_pkg::*;
#(
  parameter int         NREQ = 2,
  parameter int         DW   = 32,
  parameter logic [9:0] WREG = REG_CDC_CONF
) (
  input  logic                      clk,
  input  logic                      rst,
  networkadapter_conf_arb_if.slave  bus,
  output state_t                    o_dbg_state
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          r_state;
  state_t          w_next_state;
  logic [LW-1:0]   r_last;
  logic [LW-1:0]   r_gidx;
  logic [LW-1:0]   w_gidx;
  logic [NREQ-1:0] w_grant;
  logic            r_we;
  logic [NREQ-1:0] r_ack;
  logic [NREQ-1:0] r_err;
  logic            r_conf_en;
  logic            r_conf_we;
  logic [15:0]     r_conf_addr;
  logic [DW-1:0]   r_conf_din;
  logic [DW-1:0]   r_dout;
  logic [15:0]     w_sel_addr;
  logic            w_sel_we;
  logic [DW-1:0]   w_sel_din;

  arb_rr #(.NREQ(NREQ), .LW(LW)) u_arb_rr (
    .i_req   (bus.req_valid),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) w_gidx = LW'(i);
    end
  end

  assign w_sel_addr = bus.req_addr[16*w_gidx +: 16];
  assign w_sel_we   = bus.req_we[w_gidx];
  assign w_sel_din  = bus.req_din[DW*w_gidx +: DW];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:   if (|bus.req_valid) w_next_state = ST_ACCESS;
      ST_ACCESS: w_next_state = ST_RESP;
      ST_RESP:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // All port drives are registered, so each is loaded on the edge entering the state that shows it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last      <= LW'(NREQ - 1);
      r_gidx      <= '0;
      r_we        <= 1'b0;
      r_ack       <= '0;
      r_err       <= '0;
      r_conf_en   <= 1'b0;
      r_conf_we   <= 1'b0;
      r_conf_addr <= '0;
      r_conf_din  <= '0;
      r_dout      <= '0;
    end else begin
      r_ack     <= '0;
      r_err     <= '0;
      r_conf_en <= 1'b0;
      r_conf_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|bus.req_valid) begin
            r_gidx      <= w_gidx;
            r_we        <= w_sel_we;
            r_conf_addr <= w_sel_addr;
            r_conf_din  <= w_sel_din;
            r_conf_en   <= 1'b1;
            r_conf_we   <= w_sel_we && (word_idx(w_sel_addr) == WREG);
          end
        end
        ST_ACCESS: begin
          r_dout        <= bus.conf_dout;
          r_ack[r_gidx] <= 1'b1;
          r_err[r_gidx] <= r_we && (word_idx(r_conf_addr) != WREG);
        end
        ST_RESP: r_last <= r_gidx;
        default: ;
      endcase
    end
  end

  assign bus.req_ack   = r_ack;
  assign bus.req_err   = r_err;
  assign bus.req_dout  = r_dout;
  assign bus.conf_addr = r_conf_addr;
  assign bus.conf_din  = r_conf_din;
  assign bus.conf_en   = r_conf_en;
  assign bus.conf_we   = r_conf_we;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_networkadapter_conf_arb.sv
// Directed and randomized checks of the NA config arbiter against a round-robin reference model.
module tb_networkadapter_conf_arb;
  import networkadapter_conf_arb_pkg::*;

  localparam int         NREQ = 2;
  localparam int         DW   = 32;
  localparam logic [9:0] WREG = 10'h42;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] rd_base = '0;
  state_t        dbg_state;
  int            n_checks = 0;
  int            n_errors = 0;

  // Reference model state
  int            model_last = NREQ - 1;
  logic [DW-1:0] model_dout = '0;
  logic [DW-1:0] exp_q[$];

  // Stimulus for the next transaction
  logic [NREQ-1:0] t_vld;
  logic [15:0]     t_addr[NREQ];
  logic            t_we[NREQ];
  logic [DW-1:0]   t_din[NREQ];

  networkadapter_conf_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();

  networkadapter_conf_arb #(.NREQ(NREQ), .DW(DW), .WREG(WREG)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Configuration register port model: read data depends on the presented address.
  assign bus.conf_dout = rd_base ^ {16'h0, bus.conf_addr};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [15:0] a, input logic we,
                         input logic [DW-1:0] d);
    bus.req_valid[i]         = v;
    bus.req_addr[16*i +: 16] = a;
    bus.req_we[i]            = we;
    bus.req_din[DW*i +: DW]  = d;
  endtask

  // Called just after a rising edge with the DUT in IDLE; returns one cycle after the ack cycle.
  task automatic run_txn(input string tag, input logic scramble);
    int w;
    logic exp_we, exp_err;
    logic [NREQ-1:0] exp_ack, exp_errv;
    logic [DW-1:0] exp_dout;
    for (int i = 0; i < NREQ; i++) set_req(i, t_vld[i], t_addr[i], t_we[i], t_din[i]);
    w = -1;
    for (int k = 1; k <= NREQ; k++) begin
      if (w < 0 && t_vld[(model_last + k) % NREQ]) w = (model_last + k) % NREQ;
    end
    exp_we  = t_we[w] && (t_addr[w][11:2] == WREG);
    exp_err = t_we[w] && (t_addr[w][11:2] != WREG);
    exp_q.push_back(rd_base ^ {16'h0, t_addr[w]});
    exp_ack = '0;  exp_ack[w] = 1'b1;
    exp_errv = '0; exp_errv[w] = exp_err;

    @(negedge clk);
    chk({tag, ".idle_en"},   64'(bus.conf_en), 64'd0);
    chk({tag, ".idle_ack"},  64'(bus.req_ack), 64'd0);
    chk({tag, ".hold_dout"}, 64'(bus.req_dout), 64'(model_dout));
    @(posedge clk); #1;
    if (scramble) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), $urandom);
    end
    @(negedge clk);
    chk({tag, ".state"},     64'(dbg_state), 64'(ST_ACCESS));
    chk({tag, ".conf_en"},   64'(bus.conf_en), 64'd1);
    chk({tag, ".conf_we"},   64'(bus.conf_we), 64'(exp_we));
    chk({tag, ".conf_addr"}, 64'(bus.conf_addr), 64'(t_addr[w]));
    chk({tag, ".conf_din"},  64'(bus.conf_din), 64'(t_din[w]));
    chk({tag, ".early_ack"}, 64'(bus.req_ack), 64'd0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    exp_dout = exp_q.pop_front();
    chk({tag, ".ack"},       64'(bus.req_ack), 64'(exp_ack));
    chk({tag, ".err"},       64'(bus.req_err), 64'(exp_errv));
    chk({tag, ".dout"},      64'(bus.req_dout), 64'(exp_dout));
    chk({tag, ".resp_en"},   64'(bus.conf_en), 64'd0);
    chk({tag, ".resp_we"},   64'(bus.conf_we), 64'd0);
    model_dout = exp_dout;
    model_last = w;
    @(posedge clk); #1;
  endtask

  task automatic reset_model();
    model_last = NREQ - 1;
    model_dout = '0;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_we    = '0;
    bus.req_din   = '0;
    rd_base       = 32'h0000_0005;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.state",     64'(dbg_state), 64'(ST_IDLE));
    chk("rst.conf_en",   64'(bus.conf_en), 64'd0);
    chk("rst.conf_we",   64'(bus.conf_we), 64'd0);
    chk("rst.ack",       64'(bus.req_ack), 64'd0);
    chk("rst.err",       64'(bus.req_err), 64'd0);
    chk("rst.dout",      64'(bus.req_dout), 64'd0);
    chk("rst.conf_addr", 64'(bus.conf_addr), 64'd0);
    chk("rst.conf_din",  64'(bus.conf_din), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    reset_model();

    // Requester 0 reads 0x0000, read data 5
    t_vld = 2'b01;
    t_addr[0] = 16'h0000; t_we[0] = 1'b0; t_din[0] = 32'h0;
    t_addr[1] = 16'h0000; t_we[1] = 1'b0; t_din[1] = 32'h0;
    run_txn("rd0", 1'b0);

    // Requester 1 writes 3 to the CDC config register
    t_vld = 2'b10;
    t_addr[1] = 16'h0108; t_we[1] = 1'b1; t_din[1] = 32'h0000_0003;
    run_txn("wr1", 1'b0);

    // Requester 0 writes a read-only address
    t_vld = 2'b01;
    t_addr[0] = 16'h0004; t_we[0] = 1'b1; t_din[0] = 32'hDEAD_BEEF;
    run_txn("wrerr0", 1'b0);

    // Randomized transactions, fields scrambled after grant
    for (int n = 0; n < 24; n++) begin
      rd_base = $urandom;
      t_vld   = NREQ'($urandom_range(1, 3));
      for (int i = 0; i < NREQ; i++) begin
        t_addr[i] = ($urandom_range(0, 2) == 0) ? 16'h0108 : (16'($urandom) & 16'hFFFC);
        t_we[i]   = 1'($urandom_range(0, 1));
        t_din[i]  = $urandom;
      end
      run_txn($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)));
    end

    // Both requesters held from reset: acks alternate every third cycle
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rd_base = 32'h1234_0000;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 16'h0000, 1'b0, 32'h0);
    rst = 1'b1;
    reset_model();
    for (int c = 0; c < 12; c++) begin
      logic [NREQ-1:0] exp_ack;
      exp_ack = '0;
      if (c % 3 == 2) exp_ack[(c / 3) % NREQ] = 1'b1;
      @(negedge clk);
      chk($sformatf("rr.ack%0d", c), 64'(bus.req_ack), 64'(exp_ack));
      chk($sformatf("rr.en%0d", c),  64'(bus.conf_en), 64'(c % 3 == 1));
      @(posedge clk); #1;
    end
    bus.req_valid = '0;
    model_last = 1;
    model_dout = rd_base;
    @(posedge clk); #1;

    // Reset in the ACCESS cycle of a read aborts it; held request is re-granted after release
    rd_base = 32'h0000_00A0;
    set_req(0, 1'b1, 16'h0010, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk("abort.access_en", 64'(bus.conf_en), 64'd1);
    rst = 1'b0;
    #1;
    chk("abort.en_now",  64'(bus.conf_en), 64'd0);
    chk("abort.ack_now", 64'(bus.req_ack), 64'd0);
    chk("abort.state",   64'(dbg_state), 64'(ST_IDLE));
    repeat (2) begin
      @(negedge clk);
      chk("abort.no_ack", 64'(bus.req_ack), 64'd0);
      chk("abort.no_err", 64'(bus.req_err), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    reset_model();
    t_vld = 2'b01;
    t_addr[0] = 16'h0010; t_we[0] = 1'b0; t_din[0] = 32'h0;
    run_txn("regrant", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
